// File: rtl/intr_pkg.sv
// Shared types for the interrupt controller: dispatch FSM states and source indices.
package intr_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DISP1,
      DISP2,
      SERV1,
      SERV2,
      RET
   } state_e;

   localparam int SRC1    = 0;
   localparam int SRC2    = 1;
   localparam int NUM_SRC = 2;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for one asynchronous request line with rising-edge detect.
module sync_edge
   import intr_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic async_in,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/intr_ctrl.sv
// Two-source fixed-priority interrupt controller: latches requests, dispatches one
// strobe per interrupt and blocks nesting until return-from-interrupt.
module intr_ctrl
   import intr_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       irq1_in,
   input  logic       irq2_in,
   input  logic [1:0] mask,
   input  logic       gie_set,
   input  logic       gie_clr,
   input  logic       inhibit,
   input  logic       reti,
   input  logic       clr_ovf,
   output logic       s_intr1,
   output logic       s_intr2,
   output logic [1:0] pending,
   output logic [1:0] in_service,
   output logic [1:0] overflow
);

   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] elig;
   logic [NUM_SRC-1:0] disp;
   logic [NUM_SRC-1:0] pend_q, pend_d;
   logic [NUM_SRC-1:0] ovf_q, ovf_d;
   logic [NUM_SRC-1:0] insv_q, insv_d;
   logic               gie_q, gie_d;
   logic               s1_q, s1_d, s2_q, s2_d;
   state_e             state_q, state_d;

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync1 (
      .clk      (clk),
      .reset    (reset),
      .async_in (irq1_in),
      .rise     (rise[SRC1])
   );

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync2 (
      .clk      (clk),
      .reset    (reset),
      .async_in (irq2_in),
      .rise     (rise[SRC2])
   );

   assign elig = pend_q & ~mask & {NUM_SRC{gie_q & ~inhibit}};

   // Only IDLE may dispatch, so SERVx and RET naturally hold off any nesting.
   always_comb begin
      state_d = state_q;
      disp    = '0;
      case (state_q)
         IDLE: begin
            if (elig[SRC1]) begin
               state_d    = DISP1;
               disp[SRC1] = 1'b1;
            end else if (elig[SRC2]) begin
               state_d    = DISP2;
               disp[SRC2] = 1'b1;
            end
         end
         DISP1:   state_d = SERV1;
         DISP2:   state_d = SERV2;
         SERV1:   if (reti) state_d = RET;
         SERV2:   if (reti) state_d = RET;
         RET:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A rise coinciding with dispatch re-arms pending rather than counting as overflow.
   always_comb begin
      pend_d = (pend_q & ~disp) | rise;
      ovf_d  = (ovf_q & ~{NUM_SRC{clr_ovf}}) | (rise & pend_q & ~disp);
      gie_d  = gie_clr ? 1'b0 : (gie_set ? 1'b1 : gie_q);
      s1_d   = (state_d == DISP1);
      s2_d   = (state_d == DISP2);
      insv_d = {(state_d == SERV2) || (state_d == DISP2),
                (state_d == SERV1) || (state_d == DISP1)};
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         pend_q  <= '0;
         ovf_q   <= '0;
         gie_q   <= 1'b0;
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         insv_q  <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
         gie_q   <= gie_d;
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         insv_q  <= insv_d;
      end
   end

   assign s_intr1    = s1_q;
   assign s_intr2    = s2_q;
   assign pending    = pend_q;
   assign in_service = insv_q;
   assign overflow   = ovf_q;

endmodule
